// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// The generator drives every signal here except en.
interface vga_timing_gen_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           en;
    logic           pix_en;
    logic           vgaclk;
    logic           hsync;
    logic           vsync;
    logic           sync_b;
    logic           blank_b;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  en,
        output pix_en, vgaclk, hsync, vsync, sync_b, blank_b,
        output x, y, line_start, frame_start
    );

    modport slave (
        output en,
        input  pix_en, vgaclk, hsync, vsync, sync_b, blank_b,
        input  x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: a phase accumulator produces the pixel
// enable and vgaclk, and x/y counters drive the registered sync, blank and strobe outputs.
module vga_timing_gen #(
    parameter int   ACC_W     = 16,
    parameter int   INC       = 34372,
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   X_W       = 10,
    parameter int   Y_W       = 10
) (
    input  logic            clk,
    input  logic            reset,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [ACC_W-1:0] INC_V    = ACC_W'(INC);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0]   X_ACT    = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]   Y_ACT    = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             pix_en_q, pix_en_d;
    logic             vgaclk_q, vgaclk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             sync_b_q, sync_b_d;
    logic             blank_b_q, blank_b_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        sum           = {1'b0, acc_q} + {1'b0, INC_V};
        acc_d         = '0;
        pix_en_d      = 1'b0;
        vgaclk_d      = 1'b0;
        x_d           = '0;
        y_d           = '0;
        hsync_d       = ~HSYNC_POL;
        vsync_d       = ~VSYNC_POL;
        sync_b_d      = 1'b0;
        blank_b_d     = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        // en low parks everything at the reset values so a restart begins at (0,0) without a strobe
        if (vga.en) begin
            acc_d    = sum[ACC_W-1:0];
            pix_en_d = sum[ACC_W];
            vgaclk_d = sum[ACC_W-1];
            x_d      = x_q;
            y_d      = y_q;
            if (pix_en_q) begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end

            // Decodes use the next counter values so they register alongside the x/y they describe
            hsync_d       = (x_d >= HS_START && x_d < HS_END) ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = (y_d >= VS_START && y_d < VS_END) ? VSYNC_POL : ~VSYNC_POL;
            blank_b_d     = (x_d < X_ACT) && (y_d < Y_ACT);
            line_start_d  = pix_en_q && (x_d == '0);
            frame_start_d = line_start_d && (y_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            pix_en_q      <= 1'b0;
            vgaclk_q      <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            sync_b_q      <= 1'b0;
            blank_b_q     <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            x_q           <= x_d;
            y_q           <= y_d;
            pix_en_q      <= pix_en_d;
            vgaclk_q      <= vgaclk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            sync_b_q      <= sync_b_d;
            blank_b_q     <= blank_b_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.pix_en      = pix_en_q;
    assign vga.vgaclk      = vgaclk_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.sync_b      = sync_b_q;
    assign vga.blank_b     = blank_b_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
endmodule
